usb_ep_in_packetizer: RTL and testbench

//  Device-side producer for an IN endpoint FIFO. Accepts an application byte stream (valid/ready)
//  and stages up to MAX_PKT_SIZE bytes in a local buffer. It copies each staged packet into the

---
 rtl/usb_ep_in_packetizer.sv | 172 +++++++++++++++++
 tb/tb_usb_ep_in_packetizer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_in_packetizer.sv
// IN endpoint packetizer: stages application bytes, then copies them into the
// endpoint FIFO as one fill transaction, replaying the staged copy after an abort.
module usb_ep_in_packetizer #(
    parameter int MAX_PKT_SIZE = 64,
    parameter int RETRY_DELAY  = 16,
    parameter int CNT_WID      = $clog2(MAX_PKT_SIZE + 1)
) (
    input  logic       clk12_i,
    input  logic       rst_i,
    input  logic       app_valid_i,
    input  logic [7:0] app_data_i,
    input  logic       app_last_i,
    output logic       app_ready_o,
    input  logic       flush_i,
    output logic       EP_IN_fillTransDone_o,
    output logic       EP_IN_fillTransSuccess_o,
    output logic       EP_IN_dataValid_o,
    output logic [7:0] EP_IN_data_o,
    input  logic       EP_IN_full_i,
    output logic       busy_o,
    output logic       pktCommitted_o,
    output logic       retry_o
);

    localparam int IDX_WID = (MAX_PKT_SIZE > 1) ? $clog2(MAX_PKT_SIZE) : 1;
    localparam int BO_WID  = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY + 1) : 1;

    localparam logic [CNT_WID-1:0] MAX_CNT = CNT_WID'(MAX_PKT_SIZE);
    localparam logic [CNT_WID-1:0] CNT_ONE = CNT_WID'(1);
    localparam logic [BO_WID-1:0]  BO_LOAD = BO_WID'(RETRY_DELAY);
    localparam logic [BO_WID-1:0]  BO_ONE  = BO_WID'(1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_COPY,
        S_COMMIT,
        S_ABORT,
        S_BACKOFF
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_WID-1:0] count;
    logic [CNT_WID-1:0] count_nxt;
    logic [CNT_WID-1:0] rd_idx;
    logic [CNT_WID-1:0] rd_idx_nxt;
    logic [BO_WID-1:0]  backoff;
    logic [BO_WID-1:0]  backoff_nxt;

    logic [7:0] pkt_buf [MAX_PKT_SIZE];

    logic accept;
    logic wr_en;
    logic close;
    logic [CNT_WID-1:0] count_inc;
    logic [CNT_WID-1:0] rd_inc;

    assign count_inc = count + CNT_ONE;
    assign rd_inc    = rd_idx + CNT_ONE;

    always_ff @(posedge clk12_i) begin
        if (rst_i) begin
            state   <= S_COLLECT;
            count   <= '0;
            rd_idx  <= '0;
            backoff <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            rd_idx  <= rd_idx_nxt;
            backoff <= backoff_nxt;
        end
    end

    // Staging storage needs no reset: count gates what is ever read back.
    always_ff @(posedge clk12_i) begin
        if (wr_en) begin
            pkt_buf[count[IDX_WID-1:0]] <= app_data_i;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        rd_idx_nxt  = rd_idx;
        backoff_nxt = backoff;
        accept      = 1'b0;
        wr_en       = 1'b0;
        close       = 1'b0;

        app_ready_o              = 1'b0;
        EP_IN_fillTransDone_o    = 1'b0;
        EP_IN_fillTransSuccess_o = 1'b0;
        EP_IN_dataValid_o        = 1'b0;
        EP_IN_data_o             = 8'h00;
        busy_o                   = 1'b0;
        pktCommitted_o           = 1'b0;
        retry_o                  = 1'b0;

        unique case (state)
            S_COLLECT: begin
                app_ready_o = (count < MAX_CNT);
                accept      = app_valid_i && app_ready_o;
                wr_en       = accept;
                if (accept) begin
                    count_nxt = count_inc;
                end
                // A byte arriving with flush joins the packet being closed.
                close = (accept && ((count_inc == MAX_CNT) || app_last_i))
                     || (flush_i && ((count != '0) || accept));
                if (close) begin
                    state_nxt  = S_COPY;
                    rd_idx_nxt = '0;
                end
            end
            S_COPY: begin
                busy_o       = 1'b1;
                EP_IN_data_o = pkt_buf[rd_idx[IDX_WID-1:0]];
                if (EP_IN_full_i) begin
                    state_nxt = S_ABORT;
                end else begin
                    EP_IN_dataValid_o = 1'b1;
                    rd_idx_nxt        = rd_inc;
                    if (rd_inc == count) begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                busy_o                   = 1'b1;
                EP_IN_fillTransDone_o    = 1'b1;
                EP_IN_fillTransSuccess_o = 1'b1;
                pktCommitted_o           = 1'b1;
                count_nxt                = '0;
                state_nxt                = S_COLLECT;
            end
            S_ABORT: begin
                busy_o                = 1'b1;
                EP_IN_fillTransDone_o = 1'b1;
                retry_o               = 1'b1;
                backoff_nxt           = BO_LOAD;
                state_nxt             = S_BACKOFF;
            end
            S_BACKOFF: begin
                busy_o = 1'b1;
                if (backoff != '0) begin
                    backoff_nxt = backoff - BO_ONE;
                end else if (!EP_IN_full_i) begin
                    state_nxt  = S_COPY;
                    rd_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_COLLECT;
            end
        endcase

        // Nothing reaches the FIFO or the application while reset is held.
        if (rst_i) begin
            app_ready_o              = 1'b0;
            EP_IN_fillTransDone_o    = 1'b0;
            EP_IN_fillTransSuccess_o = 1'b0;
            EP_IN_dataValid_o        = 1'b0;
            EP_IN_data_o             = 8'h00;
            busy_o                   = 1'b0;
            pktCommitted_o           = 1'b0;
            retry_o                  = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_ep_in_packetizer.sv
// Scoreboard bench for usb_ep_in_packetizer: packet-level reference model
// fed by the driver, FIFO-side monitor pops and compares committed packets.
module tb_usb_ep_in_packetizer;

    localparam int MAX = 64;
    localparam int RD  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       app_valid = 1'b0;
    logic [7:0] app_data = 8'h00;
    logic       app_last = 1'b0;
    logic       app_ready;
    logic       flush = 1'b0;
    logic       done;
    logic       succ;
    logic       dv;
    logic [7:0] data;
    logic       full = 1'b0;
    logic       busy;
    logic       pkt;
    logic       retry;

    always #5 clk = ~clk;

    usb_ep_in_packetizer #(
        .MAX_PKT_SIZE(MAX),
        .RETRY_DELAY (RD)
    ) dut (
        .clk12_i                 (clk),
        .rst_i                   (rst),
        .app_valid_i             (app_valid),
        .app_data_i              (app_data),
        .app_last_i              (app_last),
        .app_ready_o             (app_ready),
        .flush_i                 (flush),
        .EP_IN_fillTransDone_o   (done),
        .EP_IN_fillTransSuccess_o(succ),
        .EP_IN_dataValid_o       (dv),
        .EP_IN_data_o            (data),
        .EP_IN_full_i            (full),
        .busy_o                  (busy),
        .pktCommitted_o          (pkt),
        .retry_o                 (retry)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] cur[$];
    logic [7:0] expb[$];
    int         expl[$];
    logic [7:0] trans[$];

    int commits = 0;
    int aborts = 0;
    int abort_writes = -1;
    int last_len = -1;
    int last_tail = -1;
    bit gap_armed = 1'b0;
    int gap = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference packetization rules applied to the handshake of this cycle.
    task automatic model();
        bit acc;
        if (rst) begin
            cur.delete();
            expb.delete();
            expl.delete();
        end else if (app_ready) begin
            acc = app_valid;
            if (acc) cur.push_back(app_data);
            if ((acc && (cur.size() == MAX || app_last)) ||
                (flush && cur.size() > 0)) begin
                expl.push_back(cur.size());
                foreach (cur[i]) expb.push_back(cur[i]);
                cur.delete();
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l,
                        input logic f, input logic fu, input logic r);
        @(posedge clk);
        #1;
        app_valid = v;
        app_data  = d;
        app_last  = l;
        flush     = f;
        full      = fu;
        rst       = r;
        #1;
        model();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle();
        while ((expl.size() != 0 || busy) && n < 6000) begin
            idle();
            n++;
        end
        chk("drain_timeout", n < 6000, 1);
    endtask

    // Monitor on the FIFO fill side.
    always @(negedge clk) begin
        if (rst) begin
            chk("done_in_reset", done, 0);
            trans.delete();
            gap_armed = 1'b0;
        end else begin
            chk("pulse_rules",
                {done && dv, succ && !done, pkt != (done && succ),
                 retry != (done && !succ)}, 0);
            if (gap_armed) gap++;
            if (dv) begin
                if (gap_armed) begin
                    chk("backoff_gap_gt_delay", gap > RD, 1);
                    gap_armed = 1'b0;
                end
                trans.push_back(data);
            end
            if (done && succ) begin
                commits++;
                if (expl.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    int len;
                    int bad;
                    logic [7:0] e;
                    len = expl.pop_front();
                    bad = 0;
                    chk("pkt_len", trans.size(), len);
                    for (int i = 0; i < len; i++) begin
                        e = expb.pop_front();
                        if (i >= trans.size() || trans[i] !== e) bad++;
                    end
                    chk("pkt_data_bad_bytes", bad, 0);
                end
                last_len = trans.size();
                last_tail = (trans.size() > 0) ? int'(trans[$]) : -1;
                trans.delete();
            end else if (done) begin
                aborts++;
                abort_writes = trans.size();
                trans.delete();
                gap_armed = 1'b1;
                gap = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [3];
        int n;
        int c0;
        int a0;
        t1[0] = 8'hA1;
        t1[1] = 8'hB2;
        t1[2] = 8'hC3;

        // Reset state
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_ready", app_ready, 1);
        chk("rst_outputs", {dv, done, succ, busy, pkt, retry}, 0);
        chk("rst_data", data, 0);

        // Three-byte packet timing
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("t1_valid", dv, 1);
            chk("t1_data", data, t1[k]);
        end
        idle();
        chk("t1_commit", {done, succ, pkt, retry}, 4'b1110);
        idle();
        chk("t1_ready_again", app_ready, 1);

        // Full-size auto close
        for (int i = 0; i < MAX; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        idle();
        while (!app_ready && n < 200) begin
            n++;
            idle();
        end
        chk("t2_ready_low_cycles", n, MAX + 1);
        chk("t2_len", last_len, MAX);

        // Abort on the tenth write, then replay
        a0 = aborts;
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'(i * 3 + 7), i == 39, 1'b0, 1'b0, 1'b0);
        repeat (9) idle();
        repeat (30) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t3_abort_writes", abort_writes, 9);
        chk("t3_aborts", aborts - a0, 1);
        chk("t3_replay_len", last_len, 40);

        // Flush after five bytes, then flush with nothing staged
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("t4_len", last_len, 5);
        c0 = commits;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("t4_empty_flush_idle", {busy, dv, done}, 0);
        end
        chk("t4_no_commit", commits - c0, 0);

        // Flush together with a byte
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("t5_len", last_len, 3);
        chk("t5_tail", last_tail, 8'h55);

        // Reset in the middle of a copy
        c0 = commits;
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t6_copying", dv, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t6_outputs_clear", {dv, done, succ, busy, pkt, retry}, 0);
        chk("t6_data_clear", data, 0);
        chk("t6_ready", app_ready, 1);
        chk("t6_no_commit", commits - c0, 0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        chk("t6_new_pkt_len", last_len, 2);
        chk("t6_new_pkt_tail", last_tail, 8'h45);

        // Randomized traffic with sporadic FIFO-full
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) < 4, 1'b0);
        end
        n = 0;
        while (cur.size() > 0 && n < 6000) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("rand_flush_timeout", n < 6000, 1);
        drain();
        chk("final_exp_empty", expl.size(), 0);
        chk("final_trans_empty", trans.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
